mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port req  input  1  access request, sampled only in IDLE.
REQ-004 SHALL have port op  input  3  000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu, 101 sb, 110 sh, 111 sw.
REQ-005 SHALL have port addr  input  32  byte address of access.
REQ-006 SHALL have port wdata  input  32  store data, LSB-aligned for sb/sh.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port rdata  output  32  extended load result.
REQ-010 SHALL have port misalign  output  1  alignment fault for completed request.
REQ-011 SHALL have port mem_addr  output  30  word address to data memory.
REQ-012 SHALL have port mem_re  output  1  memory read strobe; mem_rdata valid the following cycle.
REQ-013 SHALL have port mem_we  output  1  memory word write strobe.
REQ-014 SHALL have port mem_wdata  output  32  memory write word.
REQ-015 SHALL have port mem_rdata  input  32  memory read word.

Function
REQ-016 SHALL implement FSM states IDLE, RD, CAP, WR, DONE; all outputs Moore, from registered state/data only, no combinational path from req/op/addr/wdata.
REQ-017 SHALL, in IDLE with req=1, latch op, addr, wdata and clear misalign; in any other state req is ignored (no queuing).
REQ-018 SHALL flag misaligned when halfword op and addr[0]=1, or lw/sw and addr[1:0]!=00; byte ops never misaligned.
REQ-019 SHALL route IDLE->DONE with misalign=1 for a misaligned request, issuing no mem_re/mem_we.
REQ-020 SHALL route aligned loads and sb/sh IDLE->RD->CAP; loads CAP->DONE; sb/sh CAP->WR->DONE; sw IDLE->WR->DONE; DONE->IDLE unconditionally.
REQ-021 SHALL drive mem_re=1 only in RD, mem_we=1 only in WR, each for exactly one cycle per access; mem_addr = latched addr[31:2] whenever busy.
REQ-022 SHALL use little-endian lanes: byte k (addr[1:0]=k) occupies bits 8k+7:8k; halfword at addr[1]=h occupies bits 16h+15:16h.
REQ-023 SHALL, in CAP, register mem_rdata; loads select lane and sign-extend (lb, lh) or zero-extend (lbu, lhu) into rdata.
REQ-024 SHALL, for sb/sh, form mem_wdata in WR by replacing only the addressed lane of the CAP-captured word with wdata[7:0]/wdata[15:0]; sw drives wdata unchanged.
REQ-025 SHALL hold rdata until the next load completes; stores and misaligned requests leave rdata unchanged.
REQ-026 SHALL assert done=1 only in DONE; misalign valid with done and held until next accepted request.
REQ-027 SHALL yield done latency after acceptance cycle (cycle 0): loads cycle 3, sw cycle 2, sb/sh cycle 4, misaligned cycle 1.
REQ-028 SHALL accept a req held continuously high again in the IDLE cycle after DONE (one idle cycle between accesses).

Reset
REQ-029 SHALL, on reset=0, immediately force state IDLE and busy, done, misalign, mem_re, mem_we, rdata, mem_wdata, mem_addr to 0, independent of clk.
REQ-030 SHALL abort any in-flight access on reset with no partial or later write; reset before WR of sb/sh leaves memory unchanged.
REQ-031 SHALL leave IDLE only on a rising edge after reset returns high.

Verification
REQ-032 SHALL cover: word 0x20 (byte addr 0x80) = 0x8000FFFA; lb addr 0x80 -> rdata 0xFFFFFFFA, done at cycle 3, one mem_re, no mem_we.
REQ-033 SHALL cover: same word; lhu addr 0x82 -> rdata 0x00008000; lh addr 0x80 -> rdata 0xFFFFFFFA.
REQ-034 SHALL cover: sb wdata 0x00000012 addr 0x81 -> single mem_we with mem_wdata 0x800012FA to mem_addr 0x20, done at cycle 4.
REQ-035 SHALL cover: lh addr 0x81 and sw addr 0x82 -> misalign=1, done at cycle 1, zero mem_re/mem_we, rdata unchanged.
REQ-036 SHALL cover: sh asserted, reset driven low mid-CAP -> all outputs 0 immediately, no mem_we ever, memory word unchanged.
REQ-037 SHALL cover: req held high across two lw -> second accepted in IDLE after first DONE; req pulses while busy ignored.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Requester/memory bundle for mem_access_ctrl; master drives the request and returns
// memory read data, slave is the controller.
interface mem_access_ctrl_if;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        misalign;
    logic [29:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output req, op, addr, wdata, mem_rdata,
        input  busy, done, rdata, misalign, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport slave (
        input  req, op, addr, wdata, mem_rdata,
        output busy, done, rdata, misalign, mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store sequencer over a word memory; done after 3 (load), 2 (sw), 4 (sb/sh), 1 (misaligned) cycles.
// No queuing: req is only sampled while idle, busy stays high until the DONE cycle has passed.
module mem_access_ctrl (
    input  logic             clk,
    input  logic             reset,
    mem_access_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    logic [2:0]  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] cap_q, cap_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;

    logic        req_misaligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;
    logic [31:0] store_word;

    always_comb begin
        req_misaligned = 1'b0;
        case (bus.op)
            OP_LH, OP_LHU, OP_SH: req_misaligned = bus.addr[0];
            OP_LW, OP_SW:         req_misaligned = |bus.addr[1:0];
            default:              req_misaligned = 1'b0;
        endcase
    end

    // Lane extraction works on the live memory word during CAP so rdata lands with DONE.
    always_comb begin
        ld_byte  = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half  = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (op_q)
            OP_LB:   load_val = {{24{ld_byte[7]}}, ld_byte};
            OP_LH:   load_val = {{16{ld_half[15]}}, ld_half};
            OP_LBU:  load_val = {24'h000000, ld_byte};
            OP_LHU:  load_val = {16'h0000, ld_half};
            default: load_val = bus.mem_rdata;
        endcase
    end

    // Sub-word stores are read-modify-write: only the addressed lane of the captured word changes.
    always_comb begin
        store_word = cap_q;
        case (op_q)
            OP_SB:   store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            OP_SH:   store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: store_word = wdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cap_d   = cap_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    op_d    = bus.op;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    mis_d   = req_misaligned;
                    if (req_misaligned)      state_d = S_DONE;
                    else if (bus.op == OP_SW) state_d = S_WR;
                    else                     state_d = S_RD;
                end
            end
            S_RD: state_d = S_CAP;
            S_CAP: begin
                cap_d = bus.mem_rdata;
                if (op_q == OP_SB || op_q == OP_SH) begin
                    state_d = S_WR;
                end else begin
                    rdata_d = load_val;
                    state_d = S_DONE;
                end
            end
            S_WR:    state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            cap_q   <= 32'd0;
            rdata_q <= 32'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.mem_re    = (state_q == S_RD);
    assign bus.mem_we    = (state_q == S_WR);
    assign bus.mem_addr  = addr_q[31:2];
    assign bus.mem_wdata = (state_q == S_WR) ? store_word : 32'd0;
    assign bus.rdata     = rdata_q;
    assign bus.misalign  = mis_q;
endmodule
